reset_sequencer: RTL and testbench

Consumes the power-on reset and the board PLL lock, and releases the design's reset domains one at a time in a fixed order on the 10 MHz clock. Its async reset is the inverted power-on reset, so it holds everything in reset until the POR counter expires. After that it pulses the PLL reset and waits for lock, retrying on timeout. It then de-asserts NUM_STAGES active-low stage resets, STAGE_GAP cycles apart. A debounced pushbutton or loss of lock restarts the whole sequence.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_sequencer_debouncer.sv | 47 ++++
 rtl/reset_sequencer.sv | 121 ++++++++++++
 tb/tb_reset_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seqState_t;

   localparam int RETRY_W = 4;

   // Bits needed to hold 0..maxCount-1, never less than one.
   function automatic int cntWidth(input int unsigned maxCount);
      return (maxCount < 2) ? 1 : $clog2(maxCount);
   endfunction

   function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_debouncer.sv
// Pushbutton synchroniser and debouncer; emits one press event per held press.
module button_debouncer
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic iClk,
   input  logic iReset,
   input  logic iButtonn,
   output logic oPress
);

   localparam int CW = cntWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LOW_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    syncReg;
   logic          buttonSync;
   logic [CW-1:0] lowCount;
   logic          fired;

   assign buttonSync = syncReg[1];

   // fired blocks further events until the button is seen released.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         syncReg  <= 2'b11;
         lowCount <= '0;
         fired    <= 1'b0;
         oPress   <= 1'b0;
      end else begin
         syncReg <= {syncReg[0], iButtonn};
         oPress  <= 1'b0;
         if (buttonSync) begin
            lowCount <= '0;
            fired    <= 1'b0;
         end else if (!fired) begin
            if (lowCount == LOW_LAST) begin
               oPress <= 1'b1;
               fired  <= 1'b1;
            end else begin
               lowCount <= lowCount + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: PLL reset pulse, lock wait with retry, then
// ordered release of the stage resets on the 10 MHz clock.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES      = 3,
   parameter int STAGE_GAP       = 1000,
   parameter int PLL_RST_CYCLES  = 100,
   parameter int LOCK_TIMEOUT    = 50000,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic                  iTenMHzClk,
   input  logic                  iReset,
   input  logic                  iPllLocked,
   input  logic                  iButtonn,
   output logic                  oPllReset,
   output logic [NUM_STAGES-1:0] oStageResetn,
   output logic                  oReady,
   output logic [RETRY_W-1:0]    oRetryCount
);

   localparam int TIMER_MAX = maxOf(maxOf(PLL_RST_CYCLES, LOCK_TIMEOUT), STAGE_GAP);
   localparam int TW = cntWidth(TIMER_MAX);
   localparam int SW = cntWidth(NUM_STAGES);
   localparam logic [TW-1:0] PLL_LAST   = TW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(STAGE_GAP - 1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

   logic [1:0]            lockSyncReg;
   logic                  lockSync;
   logic                  press;
   logic                  restart;
   seqState_t             state, stateNext;
   logic [TW-1:0]         timer, timerNext;
   logic [SW-1:0]         stageIdx, stageIdxNext;
   logic [NUM_STAGES-1:0] stagesNext;
   logic [RETRY_W-1:0]    retryNext;

   assign lockSync = lockSyncReg[1];

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) uDebouncer (
      .iClk    (iTenMHzClk),
      .iReset  (iReset),
      .iButtonn(iButtonn),
      .oPress  (press)
   );

   // Lock loss only matters once stages are being released.
   assign restart = press || (!lockSync && (state == RELEASE || state == RUN));

   always_comb begin
      stateNext    = state;
      timerNext    = timer + 1'b1;
      stageIdxNext = stageIdx;
      stagesNext   = oStageResetn;
      retryNext    = oRetryCount;
      if (restart) begin
         stateNext    = PLL_RST;
         timerNext    = '0;
         stageIdxNext = '0;
         stagesNext   = '0;
      end else begin
         case (state)
            PLL_RST: begin
               if (timer == PLL_LAST) begin
                  stateNext = WAIT_LOCK;
                  timerNext = '0;
               end
            end
            WAIT_LOCK: begin
               if (lockSync) begin
                  stateNext = RELEASE;
                  timerNext = '0;
               end else if (timer == LOCK_LAST) begin
                  stateNext = PLL_RST;
                  timerNext = '0;
                  if (oRetryCount != RETRY_MAX) retryNext = oRetryCount + 1'b1;
               end
            end
            RELEASE: begin
               if (timer == GAP_LAST) begin
                  timerNext            = '0;
                  stagesNext[stageIdx] = 1'b1;
                  stageIdxNext         = stageIdx + 1'b1;
                  if (stageIdx == STAGE_LAST) stateNext = RUN;
               end
            end
            RUN: timerNext = '0;
            default: stateNext = PLL_RST;
         endcase
      end
   end

   // Outputs register the next state so they change on the same edge as it.
   always_ff @(posedge iTenMHzClk or posedge iReset) begin
      if (iReset) begin
         lockSyncReg  <= '0;
         state        <= PLL_RST;
         timer        <= '0;
         stageIdx     <= '0;
         oStageResetn <= '0;
         oPllReset    <= 1'b1;
         oReady       <= 1'b0;
         oRetryCount  <= '0;
      end else begin
         lockSyncReg  <= {lockSyncReg[0], iPllLocked};
         state        <= stateNext;
         timer        <= timerNext;
         stageIdx     <= stageIdxNext;
         oStageResetn <= stagesNext;
         oPllReset    <= (stateNext == PLL_RST);
         oReady       <= (stateNext == RUN);
         oRetryCount  <= retryNext;
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed table, corner sequences
// and randomized lock/button/reset activity against an elapsed-time model.
module tb_reset_sequencer;

   localparam int N = 3;
   localparam int G = 4;
   localparam int P = 5;
   localparam int T = 20;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         lock;
   logic         btnn;
   logic         pllRst;
   logic [N-1:0] stg;
   logic         ready;
   logic [3:0]   retry;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_STAGES     (N),
      .STAGE_GAP      (G),
      .PLL_RST_CYCLES (P),
      .LOCK_TIMEOUT   (T),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .iTenMHzClk  (clk),
      .iReset      (rst),
      .iPllLocked  (lock),
      .iButtonn    (btnn),
      .oPllReset   (pllRst),
      .oStageResetn(stg),
      .oReady      (ready),
      .oRetryCount (retry)
   );

   int errors = 0;
   int checks = 0;
   int edgeNo = 0;

   // Model: phase plus edges elapsed in it; synchronisers as 2-deep queues.
   typedef enum int {M_PLL, M_WAIT, M_REL, M_RUN} mPhase_t;
   mPhase_t mPhase;
   int      mEl;
   int      mRetries;
   int      mLowRun;
   bit      mPressPend;
   bit      lockQ[$];
   bit      btnQ[$];

   function automatic void modelReset();
      mPhase     = M_PLL;
      mEl        = 0;
      mRetries   = 0;
      mLowRun    = 0;
      mPressPend = 1'b0;
      lockQ.delete(); lockQ.push_back(1'b0); lockQ.push_back(1'b0);
      btnQ.delete();  btnQ.push_back(1'b1);  btnQ.push_back(1'b1);
   endfunction

   function automatic void modelEdge();
      bit ls, bs;
      if (rst) begin
         modelReset();
         return;
      end
      ls = lockQ.pop_front(); lockQ.push_back(lock);
      bs = btnQ.pop_front();  btnQ.push_back(btnn);
      if (mPressPend) begin
         mPhase = M_PLL; mEl = 0;
      end else begin
         case (mPhase)
            M_PLL: begin
               mEl++;
               if (mEl == P) begin mPhase = M_WAIT; mEl = 0; end
            end
            M_WAIT: begin
               mEl++;
               if (ls) begin
                  mPhase = M_REL; mEl = 0;
               end else if (mEl == T) begin
                  mPhase = M_PLL; mEl = 0;
                  if (mRetries < 15) mRetries++;
               end
            end
            M_REL: begin
               if (!ls) begin
                  mPhase = M_PLL; mEl = 0;
               end else begin
                  mEl++;
                  if (mEl == N * G) mPhase = M_RUN;
               end
            end
            default: begin
               if (!ls) begin mPhase = M_PLL; mEl = 0; end
            end
         endcase
      end
      mLowRun    = bs ? 0 : mLowRun + 1;
      mPressPend = (mLowRun == D);
   endfunction

   function automatic logic [N-1:0] modelStages();
      int mask;
      if (mPhase == M_RUN) return '1;
      if (mPhase != M_REL) return '0;
      mask = (1 << (mEl / G)) - 1;
      return mask[N-1:0];
   endfunction

   task automatic check(input string name, input logic ePll, input logic [N-1:0] eStg,
                        input logic eRdy, input logic [3:0] eRetry);
      checks++;
      if ({pllRst, stg, ready, retry} !== {ePll, eStg, eRdy, eRetry}) begin
         errors++;
         $display("FAIL %s edge=%0d: got pll=%b stg=%b rdy=%b retry=%0d, need pll=%b stg=%b rdy=%b retry=%0d",
                  name, edgeNo, pllRst, stg, ready, retry, ePll, eStg, eRdy, eRetry);
      end
   endtask

   task automatic checkModel(input string name);
      check(name, mPhase == M_PLL, modelStages(), mPhase == M_RUN, 4'(mRetries));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edgeNo++;
      modelEdge();
      checkModel("model");
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic assertReset();
      rst = 1'b1;
      #1;
      modelReset();
      checkModel("asyncReset");
   endtask

   typedef struct {
      int         atEdge;
      logic       lockAfter;
      logic       pll;
      logic [N-1:0] stg;
      logic       rdy;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int btnLeft;

      vecs[0]  = '{1,  1'b0, 1'b1, 3'b000, 1'b0};
      vecs[1]  = '{4,  1'b0, 1'b1, 3'b000, 1'b0};
      vecs[2]  = '{5,  1'b0, 1'b0, 3'b000, 1'b0};
      vecs[3]  = '{7,  1'b1, 1'b0, 3'b000, 1'b0};
      vecs[4]  = '{10, 1'b1, 1'b0, 3'b000, 1'b0};
      vecs[5]  = '{13, 1'b1, 1'b0, 3'b000, 1'b0};
      vecs[6]  = '{14, 1'b1, 1'b0, 3'b001, 1'b0};
      vecs[7]  = '{17, 1'b1, 1'b0, 3'b001, 1'b0};
      vecs[8]  = '{18, 1'b1, 1'b0, 3'b011, 1'b0};
      vecs[9]  = '{21, 1'b1, 1'b0, 3'b011, 1'b0};
      vecs[10] = '{22, 1'b1, 1'b0, 3'b111, 1'b1};
      vecs[11] = '{30, 1'b1, 1'b0, 3'b111, 1'b1};

      rst  = 1'b1;
      lock = 1'b0;
      btnn = 1'b1;
      #3;
      modelReset();
      check("resetState", 1'b1, 3'b000, 1'b0, 4'd0);
      steps(2);
      rst = 1'b0;
      edgeNo = 0;

      // Nominal bring-up
      for (int i = 0; i < 12; i++) begin
         while (edgeNo < vecs[i].atEdge) step();
         check($sformatf("nominal@%0d", vecs[i].atEdge), vecs[i].pll, vecs[i].stg, vecs[i].rdy, 4'd0);
         lock = vecs[i].lockAfter;
      end

      // Lock loss in RUN, then unlimited retries with saturation
      lock = 1'b0;
      steps(2);
      check("lossEdge2", 1'b0, 3'b111, 1'b1, 4'd0);
      step();
      check("lossEdge3", 1'b1, 3'b000, 1'b0, 4'd0);
      steps(25);
      check("firstRetry", 1'b1, 3'b000, 1'b0, 4'd1);
      steps(25);
      check("secondRetry", 1'b1, 3'b000, 1'b0, 4'd2);
      steps(25 * 14);
      check("retrySat", 1'b1, 3'b000, 1'b0, 4'd15);

      // Relock, then async reset while stages = 011
      lock = 1'b1;
      n = 0;
      while (stg !== 3'b011 && n < 200) begin step(); n++; end
      check("at011", 1'b0, 3'b011, 1'b0, 4'd15);
      assertReset();
      check("midReset", 1'b1, 3'b000, 1'b0, 4'd0);
      step();
      lock = 1'b0;
      rst  = 1'b0;
      edgeNo = 0;

      // Lock arriving on the timeout edge wins
      steps(22);
      lock = 1'b1;
      steps(3);
      check("lockOnTimeout", 1'b0, 3'b000, 1'b0, 4'd0);
      steps(4);
      check("stage0AfterTimeoutLock", 1'b0, 3'b001, 1'b0, 4'd0);

      // Button: glitch ignored, long hold gives exactly one restart
      steps(15);
      check("runBeforeButton", 1'b0, 3'b111, 1'b1, 4'd0);
      btnn = 1'b0;
      steps(7);
      btnn = 1'b1;
      steps(12);
      check("glitchIgnored", 1'b0, 3'b111, 1'b1, 4'd0);
      btnn = 1'b0;
      steps(10);
      check("holdEdge10", 1'b0, 3'b111, 1'b1, 4'd0);
      step();
      check("holdEdge11", 1'b1, 3'b000, 1'b0, 4'd0);
      steps(19);
      btnn = 1'b1;
      steps(40);
      check("oneRestart", 1'b0, 3'b111, 1'b1, 4'd0);

      // Randomized lock, button and reset activity
      btnLeft = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) lock = ~lock;
         if (btnLeft > 0) begin
            btnLeft--;
            if (btnLeft == 0) btnn = 1'b1;
         end else if ($urandom_range(0, 59) == 0) begin
            btnn    = 1'b0;
            btnLeft = $urandom_range(1, 14);
         end
         if ($urandom_range(0, 699) == 0) begin
            assertReset();
            step();
            rst = 1'b0;
         end else begin
            step();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
